fifo_write_arbiter: RTL and testbench

Round-robin write-side arbiter that shares one simple 4-bit FIFO write port among four producers. Each producer presents a request and a data nibble. The arbiter grants one producer at a time for a burst of up to MAX_BURST words, and drives the FIFO's write_en/data_in while honouring the FIFO's full flag. It sits directly in front of the simple FIFO, and all producers see ready/grant from it.

---
 rtl/fifo_write_arbiter.sv | 104 ++++++++++
 tb/tb_fifo_write_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among four producers, with bounded bursts
// and back-to-back hand-over between owners.
module fifo_write_arbiter #(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            req,
  input  logic [4*DATA_W-1:0]   req_data,
  input  logic                  fifo_full,
  output logic [3:0]            grant,
  output logic [3:0]            ready,
  output logic                  fifo_write_en,
  output logic [DATA_W-1:0]     fifo_data,
  output logic                  busy
);

  typedef enum logic [0:0] {StIdle, StOwn} state_e;

  state_e     state;
  logic [3:0] grant_q, grant_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic [3:0] burst_inc;
  logic [1:0] owner;
  logic       req_owner, xfer, rotate, burst_done;
  logic [1:0] scan_start, scan_idx;
  logic       pick_found;
  logic [3:0] pick_onehot;

  assign state = (grant_q == 4'b0) ? StIdle : StOwn;

  always_comb begin
    owner = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (grant_q[i]) owner = 2'(i);
    end
  end

  assign req_owner  = |(grant_q & req);
  assign xfer       = req_owner & ~fifo_full;
  assign burst_inc  = burst_cnt_q + 4'd1;
  assign burst_done = xfer && (burst_inc == 4'(MAX_BURST));
  assign rotate     = !req_owner || burst_done;

  // On release the scan starts just past the owner; a dropped owner request is already zero.
  assign scan_start = (state == StIdle) ? rr_ptr_q : owner + 2'd1;

  always_comb begin
    pick_found  = 1'b0;
    pick_onehot = 4'b0;
    scan_idx    = 2'd0;
    for (int i = 0; i < 4; i++) begin
      scan_idx = scan_start + 2'(i);
      if (!pick_found && req[scan_idx]) begin
        pick_found            = 1'b1;
        pick_onehot[scan_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state)
      StIdle: begin
        if (pick_found) begin
          grant_d     = pick_onehot;
          burst_cnt_d = 4'd0;
        end
      end
      StOwn: begin
        if (xfer) burst_cnt_d = burst_inc;
        if (rotate) begin
          rr_ptr_d    = owner + 2'd1;
          grant_d     = pick_onehot;
          burst_cnt_d = 4'd0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      grant_q     <= 4'b0;
      rr_ptr_q    <= 2'd0;
      burst_cnt_q <= 4'd0;
    end else begin
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign grant         = grant_q;
  assign busy          = (state == StOwn);
  assign ready         = grant_q & req & {4{~fifo_full}};
  assign fifo_write_en = xfer;
  assign fifo_data     = (state == StOwn) ? req_data[owner*DATA_W +: DATA_W] : '0;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: producer queues drive requests, expected words and grant
// changes are queued at stimulus time and compared as the arbiter writes and rotates.
module tb_fifo_write_arbiter;

  localparam int unsigned DW = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [3:0]      req = 4'b0;
  logic [4*DW-1:0] req_data = '0;
  logic            fifo_full = 1'b0;
  logic [3:0]      grant, ready;
  logic            fifo_write_en;
  logic [DW-1:0]   fifo_data;
  logic            busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [3:0] pq [4][$];
  logic [5:0] exp_words [$];
  logic [3:0] exp_grants [$];

  always #5 clock = ~clock;

  fifo_write_arbiter #(
    .DATA_W   (DW),
    .MAX_BURST(4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .req_data     (req_data),
    .fifo_full    (fifo_full),
    .grant        (grant),
    .ready        (ready),
    .fifo_write_en(fifo_write_en),
    .fifo_data    (fifo_data),
    .busy         (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] oh);
    idx_of = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx_of = 2'(i);
    end
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < 4; i++) begin
      req[i] = (pq[i].size() != 0);
      req_data[i*DW +: DW] = (pq[i].size() != 0) ? pq[i][0] : 4'b0;
    end
  endtask

  task automatic add_words(input int p, input int n);
    repeat (n) pq[p].push_back(4'($urandom_range(15)));
  endtask

  task automatic push_exp(input int p, input int first, input int cnt);
    for (int k = 0; k < cnt; k++) exp_words.push_back({2'(p), pq[p][first+k]});
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req       = 4'b0;
    req_data  = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < 4; i++) pq[i].delete();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  // Producers pop on each edge where their ready was seen; outputs are sampled on negedges.
  task automatic run(input int full_at, input int full_len, input int exp_idle);
    int         last = -1;
    int         nw   = 0;
    logic [3:0] prev = 4'b0;
    logic [3:0] rdy;
    bit         done = 1'b0;
    @(posedge clock);
    #1;
    fifo_full = (full_len > 0 && full_at == 0);
    drive_inputs();
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      check_eq("busy", 32'(busy), 32'(grant != 4'b0));
      check_eq("onehot", 32'($countones(grant) <= 1), 32'd1);
      check_eq("ready", 32'(ready), 32'(fifo_write_en ? grant : 4'b0));
      if (fifo_full) check_eq("wr_while_full", 32'(fifo_write_en), 32'd0);
      if (fifo_write_en) begin
        nw++;
        last = c;
        if (exp_words.size() == 0) check_eq("extra_write", 32'({idx_of(grant), fifo_data}), 32'h100);
        else check_eq("word", 32'({idx_of(grant), fifo_data}), 32'(exp_words.pop_front()));
      end
      if (grant != prev) begin
        if (exp_grants.size() == 0) check_eq("extra_grant", 32'(grant), 32'h100);
        else check_eq("grant", 32'(grant), 32'(exp_grants.pop_front()));
        prev = grant;
      end
      rdy = ready;
      if (pq[0].size() == 0 && pq[1].size() == 0 && pq[2].size() == 0 && pq[3].size() == 0 &&
          exp_grants.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(posedge clock);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (rdy[i] && pq[i].size() != 0) void'(pq[i].pop_front());
      end
      fifo_full = (c + 1 >= full_at) && (c + 1 < full_at + full_len);
      drive_inputs();
    end
    check_eq("run_done", 32'(done), 32'd1);
    check_eq("idle_cycles", 32'(last + 1 - nw), 32'(exp_idle));
    check_eq("words_left", 32'(exp_words.size()), 32'd0);
    fifo_full = 1'b0;
    exp_words.delete();
    exp_grants.delete();
    for (int i = 0; i < 4; i++) pq[i].delete();
  endtask

  initial begin
    // Reset state and reset mid-burst
    do_reset();
    @(negedge clock);
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_wen", 32'(fifo_write_en), 32'd0);
    check_eq("rst_data", 32'(fifo_data), 32'd0);
    check_eq("rst_ready", 32'(ready), 32'd0);
    @(posedge clock);
    #1;
    req      = 4'b0001;
    req_data = 16'h0008;
    @(posedge clock);
    @(negedge clock);
    check_eq("mb_grant", 32'(grant), 32'b0001);
    check_eq("mb_wen", 32'(fifo_write_en), 32'd1);
    check_eq("mb_data", 32'(fifo_data), 32'd8);
    check_eq("mb_ready", 32'(ready), 32'b0001);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_eq("mb_held", 32'(grant), 32'b0001);
    @(posedge clock);
    #1;
    reset    = 1'b1;
    req      = 4'b0010;
    req_data = 16'h0050;
    @(negedge clock);
    check_eq("mb_rst_grant", 32'(grant), 32'd0);
    check_eq("mb_rst_busy", 32'(busy), 32'd0);
    check_eq("mb_rst_wen", 32'(fifo_write_en), 32'd0);
    @(posedge clock);
    @(negedge clock);
    check_eq("mb_regrant", 32'(grant), 32'b0010);
    check_eq("mb_regrant_data", 32'(fifo_data), 32'd5);
    @(posedge clock);
    #1 req = 4'b0000;

    // Single producer, burst limit with self re-grant
    do_reset();
    pq[0] = '{4'd8, 4'd12, 4'd4, 4'd7, 4'd13};
    push_exp(0, 0, 5);
    exp_grants = '{4'b0001, 4'b0000};
    run(0, 0, 1);

    // Round robin, two full rotations
    do_reset();
    for (int i = 0; i < 4; i++) add_words(i, 8);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) push_exp(i, r * 4, 4);
    end
    exp_grants = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                   4'b0000};
    run(0, 0, 1);

    // Move rr_ptr to 2, then early release of producer 2 to producer 0
    add_words(1, 1);
    push_exp(1, 0, 1);
    exp_grants = '{4'b0010, 4'b0000};
    run(0, 0, 1);
    add_words(2, 2);
    add_words(0, 2);
    push_exp(2, 0, 2);
    push_exp(0, 0, 2);
    exp_grants = '{4'b0100, 4'b0001, 4'b0000};
    run(0, 0, 2);

    // Full stall: rr_ptr = 1, producer 1 owns, full for cycles 2..4
    add_words(1, 4);
    add_words(2, 1);
    push_exp(1, 0, 4);
    push_exp(2, 0, 1);
    exp_grants = '{4'b0010, 4'b0100, 4'b0000};
    run(2, 3, 4);

    // Sparse requests with rr_ptr = 3
    add_words(0, 2);
    add_words(2, 2);
    push_exp(0, 0, 2);
    push_exp(2, 0, 2);
    exp_grants = '{4'b0001, 4'b0100, 4'b0000};
    run(0, 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
